// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, default
// latencies and operation-class helpers used by the controller and datapath.
package mdu_ctrl_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic is_mult_op(input logic [3:0] op);
    return (op == MD_MULT)  || (op == MD_MULTU) || (op == MD_MADD) ||
           (op == MD_MADDU) || (op == MD_MSUB)  || (op == MD_MSUBU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit {hi,lo} result for every multi-cycle md operation,
// including the divide-by-zero and signed-overflow conventions.
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic [63:0] acc;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] sdiv_b;
  logic [31:0] udiv_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] dq;
  logic [31:0] dr;

  assign acc    = {hi, lo};
  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide runs on magnitudes; 0x8000_0000 / -1 then yields 0x8000_0000 rem 0.
  assign neg_a  = rs_val[31];
  assign neg_b  = rt_val[31];
  assign abs_a  = neg_a ? (32'd0 - rs_val) : rs_val;
  assign abs_b  = neg_b ? (32'd0 - rt_val) : rt_val;
  assign sdiv_b = (rt_val == 32'd0) ? 32'd1 : abs_b;
  assign udiv_b = (rt_val == 32'd0) ? 32'd1 : rt_val;
  assign uq     = abs_a / sdiv_b;
  assign ur     = abs_a % sdiv_b;
  assign sq     = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
  assign sr     = neg_a ? (32'd0 - ur) : ur;
  assign dq     = rs_val / udiv_b;
  assign dr     = rs_val % udiv_b;

  always_comb begin
    result = acc;
    case (md_op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_MADD:  result = acc + prod_s;
      MD_MADDU: result = acc + prod_u;
      MD_MSUB:  result = acc - prod_s;
      MD_MSUBU: result = acc - prod_u;
      MD_DIV:   result = (rt_val == 32'd0) ? {rs_val, 32'hFFFF_FFFF} : {sr, sq};
      MD_DIVU:  result = (rt_val == 32'd0) ? {rs_val, 32'hFFFF_FFFF} : {dr, dq};
      default:  result = acc;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: accepts one md op per start pulse, holds busy for
// the fixed latency, then commits the pending result to HI/LO.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mf_sel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int          CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      pend_q, pend_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      arith_res;

  mdu_arith u_arith (
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (arith_res)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_mult_op(md_op)) begin
            pend_d  = arith_res;
            count_d = CNT_W'(MULT_CYCLES);
            state_d = RUN;
          end else if (is_div_op(md_op)) begin
            pend_d  = arith_res;
            count_d = CNT_W'(DIV_CYCLES);
            state_d = RUN;
          end else if (md_op == MD_MTHI) begin
            hi_d = rs_val;
          end else if (md_op == MD_MTLO) begin
            lo_d = rs_val;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      // start is deliberately not looked at here; HI/LO stay frozen until commit.
      RUN: begin
        if (count_q == CNT_W'(1)) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          count_d = '0;
          state_d = IDLE;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      pend_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mf_data = mf_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with hand-computed HI/LO results.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mf_sel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  int vectors;
  int miscompares;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .mf_sel  (mf_sel),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .mf_data (mf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered and left 1ns after a rising edge; start is high for exactly one cycle.
  task automatic pulse(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    @(posedge clk); #1;
    start  = 1'b0;
    md_op  = MD_NONE;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_result(input string name, input int nb, input int exp_nb,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    vectors++;
    if (nb !== exp_nb) begin
      miscompares++;
      $display("FAIL %s busy_cycles got %0d want %0d", name, nb, exp_nb);
    end
    vectors++;
    if (hi !== exp_hi) begin
      miscompares++;
      $display("FAIL %s hi got %h want %h", name, hi, exp_hi);
    end
    vectors++;
    if (lo !== exp_lo) begin
      miscompares++;
      $display("FAIL %s lo got %h want %h", name, lo, exp_lo);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s busy_after got %b want 0", name, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || mf_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset busy=%b hi=%h lo=%h mf=%h want 0", busy, hi, lo, mf_data);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    int n;
    pulse(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    count_busy(n);
    check_result("mult_neg3x7", n, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    pulse(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    count_busy(n);
    check_result("multu", n, 5, 32'h0000_0001, 32'hFFFF_FFFE);
  endtask

  task automatic test_mt_back_to_back;
    pulse(MD_MTLO, 32'h1234, 32'd0);
    vectors++;
    if (lo !== 32'h1234 || hi !== 32'h0000_0001 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mtlo lo=%h hi=%h busy=%b want 00001234/00000001/0", lo, hi, busy);
    end
    pulse(MD_MTHI, 32'h5678, 32'd0);
    vectors++;
    if (hi !== 32'h5678 || lo !== 32'h1234 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi hi=%h lo=%h busy=%b want 00005678/00001234/0", hi, lo, busy);
    end
    mf_sel = 1'b1; #1;
    vectors++;
    if (mf_data !== 32'h5678) begin
      miscompares++;
      $display("FAIL mf_hi got %h want 00005678", mf_data);
    end
    mf_sel = 1'b0; #1;
    vectors++;
    if (mf_data !== 32'h1234) begin
      miscompares++;
      $display("FAIL mf_lo got %h want 00001234", mf_data);
    end
    pulse(4'd15, 32'hDEAD_BEEF, 32'd1);
    vectors++;
    if (hi !== 32'h5678 || lo !== 32'h1234 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL undef_op hi=%h lo=%h busy=%b want unchanged", hi, lo, busy);
    end
  endtask

  task automatic test_div;
    int n;
    pulse(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    check_result("div_neg7by2", n, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    pulse(MD_DIVU, 32'd7, 32'd0);
    count_busy(n);
    check_result("divu_by0", n, 10, 32'd7, 32'hFFFF_FFFF);
    pulse(MD_DIV, 32'hFFFF_FFFB, 32'd0);
    count_busy(n);
    check_result("div_by0", n, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    pulse(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    check_result("div_ovf", n, 10, 32'd0, 32'h8000_0000);
  endtask

  task automatic test_madd_msub;
    int n;
    pulse(MD_MTHI, 32'd0, 32'd0);
    pulse(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
    pulse(MD_MADDU, 32'd1, 32'd1);
    count_busy(n);
    check_result("maddu_carry", n, 5, 32'd1, 32'd0);
    pulse(MD_MSUB, 32'd2, 32'd3);
    count_busy(n);
    check_result("msub_borrow", n, 5, 32'd0, 32'hFFFF_FFFA);
  endtask

  task automatic test_start_during_run;
    int n;
    n = 0;
    pulse(MD_MULT, 32'd2, 32'd3);
    for (int k = 0; k < 10; k++) begin
      if (busy) n++;
      if (k == 2) begin
        start = 1'b1; md_op = MD_DIV; rs_val = 32'd100; rt_val = 32'd7;
      end else begin
        start = 1'b0; md_op = MD_NONE;
      end
      @(posedge clk); #1;
    end
    check_result("start_in_run", n, 5, 32'd0, 32'd6);
  endtask

  task automatic test_reset_mid_run;
    pulse(MD_MTHI, 32'hAAAA, 32'd0);
    pulse(MD_MULT, 32'd2, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    pulse(MD_DIV, 32'd100, 32'd7);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_before_reset got %b want 1", busy);
    end
    reset = 1'b1; #1;
    vectors++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL busy_after_reset got %b want 0", busy);
      end
    end
    vectors++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("FAIL no_commit_after_reset hi=%h lo=%h want 0/0", hi, lo);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    start  = 1'b0;
    md_op  = MD_NONE;
    rs_val = 32'd0;
    rt_val = 32'd0;
    mf_sel = 1'b0;
    reset  = 1'b1;
    test_reset();
    test_mult();
    test_mt_back_to_back();
    test_div();
    test_madd_msub();
    test_start_during_run();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
